// File: rtl/mem_stage_scheduler_pkg.sv
// Shared definitions for the memory-port stage scheduler: FSM encoding,
// stage index constants, the default read-only stage mask and a priority helper.
package mem_stage_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [2:0] LEARN_COSTS   = 3'd0;
  localparam logic [2:0] UPDATE_BELIEF = 3'd1;
  localparam logic [2:0] PREDICT_STATE = 3'd2;
  localparam logic [2:0] EVAL_POLICY   = 3'd3;
  localparam logic [2:0] READ_MODEL    = 3'd4;
  localparam logic [2:0] COMPUTE_VALUE = 3'd5;
  localparam logic [2:0] READ_PRIOR    = 3'd6;
  localparam logic [2:0] SELECT_ACTION = 3'd7;

  localparam logic [7:0] DEFAULT_RO_MASK = 8'b0101_0000;

  // Index of the lowest set bit; callers only use it when the mask is non-zero.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_scheduler_timeout.sv
// Watchdog for a granted stage: clearable, saturating cycle counter that flags
// the last permitted cycle of a stage's wait window.
module stage_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clock,
  input  logic i_nrst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Saturating wait counter; holds at all-ones instead of wrapping.
  always_ff @(posedge i_clock) begin
    if (!i_nrst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == CNT_LAST);

endmodule

// File: rtl/mem_stage_scheduler.sv
// Round-robin-in-order scheduler granting one pipeline stage at a time to a
// shared memory port, with per-round skip mask, abort and a watchdog fault.
module mem_stage_scheduler
  import mem_stage_scheduler_pkg::*;
#(
  parameter int         NUM_STAGES = 8,
  parameter int         TIMEOUT    = 1024,
  parameter logic [7:0] RO_MASK    = DEFAULT_RO_MASK
) (
  input  logic       clock,
  input  logic       nrst,
  input  logic       en,
  input  logic       abort,
  input  logic [7:0] skip_mask,
  input  logic [7:0] stage_done,
  output logic [7:0] stage_start,
  output logic [2:0] addr_select,
  output logic [2:0] wr_select,
  output logic       wr_gate,
  output logic       busy,
  output logic       round_done,
  output logic       timeout,
  output logic [2:0] fault_stage
);

  localparam logic [7:0] STAGE_MASK = 8'((16'd1 << NUM_STAGES) - 16'd1);

  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_cur;
  logic [2:0] w_next_cur;
  logic [7:0] r_skip;
  logic       w_fault;
  logic       w_expired;
  logic [7:0] w_idle_avail;
  logic [7:0] w_above;

  logic [7:0] r_stage_start;
  logic [2:0] r_addr_select;
  logic [2:0] r_wr_select;
  logic       r_wr_gate;
  logic       r_busy;
  logic       r_round_done;
  logic       r_timeout;
  logic [2:0] r_fault_stage;

  assign w_idle_avail = ~skip_mask & STAGE_MASK;
  assign w_above      = ~r_skip & STAGE_MASK & (8'hFF << ({1'b0, r_cur} + 4'd1));

  stage_timeout_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .i_clock  (clock),
    .i_nrst   (nrst),
    .i_clear  (r_state != ST_WAIT),
    .i_enable (r_state == ST_WAIT),
    .o_expired(w_expired)
  );

  // Next-state and next-stage selection; abort overrides every transition.
  always_comb begin
    w_next     = r_state;
    w_next_cur = r_cur;
    w_fault    = 1'b0;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!en) begin
            w_next = ST_IDLE;
          end else if (w_idle_avail == 8'h00) begin
            w_next = ST_FINISH;
          end else begin
            w_next     = ST_ISSUE;
            w_next_cur = lowest_set(w_idle_avail);
          end
        end
        ST_ISSUE: w_next = ST_WAIT;
        ST_WAIT: begin
          // Completion is checked before the watchdog so done wins a tie.
          if (stage_done[r_cur]) begin
            if (w_above == 8'h00) begin
              w_next = ST_FINISH;
            end else begin
              w_next     = ST_ISSUE;
              w_next_cur = lowest_set(w_above);
            end
          end else if (w_expired) begin
            w_next  = ST_FAULT;
            w_fault = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
        ST_FINISH: w_next = ST_IDLE;
        ST_FAULT: begin
          if (en) begin
            w_next = ST_FAULT;
          end else begin
            w_next = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State, latched skip mask and registered outputs derived from the current state.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state       <= ST_IDLE;
      r_cur         <= 3'd0;
      r_skip        <= 8'h00;
      r_stage_start <= 8'h00;
      r_addr_select <= 3'd0;
      r_wr_select   <= 3'd0;
      r_wr_gate     <= 1'b0;
      r_busy        <= 1'b0;
      r_round_done  <= 1'b0;
      r_timeout     <= 1'b0;
      r_fault_stage <= 3'd0;
    end else begin
      r_state <= w_next;
      r_cur   <= w_next_cur;
      if ((r_state == ST_IDLE) && en && !abort) begin
        r_skip <= skip_mask;
      end else begin
        r_skip <= r_skip;
      end
      if (abort) begin
        r_stage_start <= 8'h00;
        r_addr_select <= 3'd0;
        r_wr_select   <= 3'd0;
        r_wr_gate     <= 1'b0;
        r_busy        <= 1'b0;
        r_round_done  <= 1'b0;
      end else begin
        r_stage_start <= (r_state == ST_ISSUE) ? (8'd1 << r_cur) : 8'h00;
        r_addr_select <= ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? r_cur : 3'd0;
        r_wr_select   <= ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ? r_cur : 3'd0;
        r_wr_gate     <= (r_state == ST_WAIT) && !RO_MASK[r_cur];
        r_busy        <= (r_state != ST_IDLE);
        r_round_done  <= (r_state == ST_FINISH);
      end
      if (w_next == ST_ISSUE) begin
        r_timeout     <= 1'b0;
        r_fault_stage <= 3'd0;
      end else if (w_fault) begin
        r_timeout     <= 1'b1;
        r_fault_stage <= r_cur;
      end else begin
        r_timeout     <= r_timeout;
        r_fault_stage <= r_fault_stage;
      end
    end
  end

  assign stage_start = r_stage_start;
  assign addr_select = r_addr_select;
  assign wr_select   = r_wr_select;
  assign wr_gate     = r_wr_gate;
  assign busy        = r_busy;
  assign round_done  = r_round_done;
  assign timeout     = r_timeout;
  assign fault_stage = r_fault_stage;

endmodule

// File: tb/tb_mem_stage_scheduler.sv
// Directed self-checking bench for mem_stage_scheduler (TIMEOUT=16 instance).
module tb_mem_stage_scheduler;

  logic       clock = 1'b0;
  logic       nrst;
  logic       en;
  logic       abort;
  logic [7:0] skip_mask;
  logic [7:0] stage_done;
  logic [7:0] stage_start;
  logic [2:0] addr_select;
  logic [2:0] wr_select;
  logic       wr_gate;
  logic       busy;
  logic       round_done;
  logic       timeout;
  logic [2:0] fault_stage;

  int total = 0;
  int bad   = 0;

  mem_stage_scheduler #(.NUM_STAGES(8), .TIMEOUT(16)) dut (
    .clock      (clock),
    .nrst       (nrst),
    .en         (en),
    .abort      (abort),
    .skip_mask  (skip_mask),
    .stage_done (stage_done),
    .stage_start(stage_start),
    .addr_select(addr_select),
    .wr_select  (wr_select),
    .wr_gate    (wr_gate),
    .busy       (busy),
    .round_done (round_done),
    .timeout    (timeout),
    .fault_stage(fault_stage)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One round: stage order[i] starts, its done is raised 3 cycles after the start
  // pulse, so each stage occupies 5 cycles; noise drives non-current done bits.
  task automatic run_round(input string tag, input logic [7:0] skip, input int n,
                           input logic [23:0] order, input logic [7:0] noise);
    logic [7:0] exp_start;
    logic [2:0] exp_sel;
    logic [2:0] stg;
    logic       exp_gate;
    int         i;
    int         p;
    skip_mask  = skip;
    stage_done = noise;
    en         = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 1; t <= 5 * n + 1; t++) begin
      tick();
      i = (t - 1) / 5;
      p = (t - 1) % 5;
      stg       = (i < n) ? order[3*i +: 3] : 3'd0;
      exp_start = ((i < n) && (p == 0)) ? (8'd1 << stg) : 8'h00;
      exp_sel   = (i < n) ? stg : 3'd0;
      exp_gate  = (i < n) && (p >= 1) && (stg != 3'd4) && (stg != 3'd6);
      check({tag, "_start"}, 32'(stage_start), 32'(exp_start));
      check({tag, "_addr"}, 32'(addr_select), 32'(exp_sel));
      check({tag, "_wrsel"}, 32'(wr_select), 32'(exp_sel));
      check({tag, "_wrgate"}, 32'(wr_gate), 32'(exp_gate));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_rdone"}, 32'(round_done), (t == 5 * n + 1) ? 32'd1 : 32'd0);
      if ((i < n) && (p == 3)) stage_done = noise | (8'd1 << stg);
      else stage_done = noise;
    end
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_rdone"}, 32'(round_done), 32'd0);
    stage_done = 8'h00;
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; abort = 1'b0; skip_mask = 8'h00; stage_done = 8'h00;
    tick();
    tick();
    check("reset_outs", 32'({stage_start, addr_select, wr_select, wr_gate, busy,
                             round_done, timeout, fault_stage}), 32'd0);
    nrst = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Full round, all eight stages in order.
    run_round("full", 8'h00, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'h00);

    // Stages 1 and 2 skipped while their done bits are held high as noise.
    run_round("skip12", 8'b0000_0110, 6,
              {3'd0, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd0}, 8'b0000_0110);

    // Everything skipped: round_done alone, two cycles after en.
    run_round("allskip", 8'hFF, 0, 24'd0, 8'h00);

    // Stage 5 never completes: fault after 16 WAIT cycles, held while en stays high.
    skip_mask = 8'hDF; en = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) tick();
    check("to_before", 32'(timeout), 32'd0);
    tick();
    check("to_set", 32'(timeout), 32'd1);
    check("to_stage", 32'(fault_stage), 32'd5);
    tick();
    tick();
    check("to_hold_busy", 32'(busy), 32'd1);
    check("to_hold_addr", 32'(addr_select), 32'd0);
    check("to_hold_gate", 32'(wr_gate), 32'd0);
    en = 1'b0;
    tick();
    tick();
    check("to_rec_busy", 32'(busy), 32'd0);
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_sticky_stage", 32'(fault_stage), 32'd5);

    // Done coincides with the watchdog boundary: done wins; next ISSUE clears the fault.
    skip_mask = 8'hFE; en = 1'b1;
    tick();
    en = 1'b0;
    check("clr_timeout", 32'(timeout), 32'd0);
    check("clr_stage", 32'(fault_stage), 32'd0);
    for (int k = 1; k <= 16; k++) tick();
    stage_done = 8'h01;
    tick();
    stage_done = 8'h00;
    check("tie_no_timeout", 32'(timeout), 32'd0);
    tick();
    check("tie_rdone", 32'(round_done), 32'd1);
    check("tie_no_timeout2", 32'(timeout), 32'd0);
    tick();

    // Stale done held through ISSUE is only honoured in WAIT.
    skip_mask = 8'hFB; stage_done = 8'h04; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check("stale_start", 32'(stage_start), 32'h04);
    tick();
    check("stale_no_early_done", 32'(round_done), 32'd0);
    tick();
    check("stale_rdone", 32'(round_done), 32'd1);
    stage_done = 8'h00;
    tick();

    // Abort during WAIT of stage 3.
    skip_mask = 8'hF7; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check("ab_start", 32'(stage_start), 32'h08);
    tick();
    check("ab_wait_gate", 32'(wr_gate), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_outs", 32'({stage_start, addr_select, wr_gate, round_done}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ab_after_rdone", 32'(round_done), 32'd0);
      check("ab_after_busy", 32'(busy), 32'd0);
    end

    // Reset pulled low mid-WAIT of stage 0.
    skip_mask = 8'hFE; en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    check("rst_pre_gate", 32'(wr_gate), 32'd1);
    nrst = 1'b0;
    tick();
    check("rst_outs", 32'({stage_start, addr_select, wr_select, wr_gate, busy,
                           round_done, timeout, fault_stage}), 32'd0);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_after", 32'({stage_start, busy, round_done}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_scheduler.md
MEM_STAGE_SCHEDULER -- requirements
Module: mem_stage_scheduler

Interface
REQ-001 Parameter NUM_STAGES, default 8, number of pipeline stages sharing the single memory port (max 8).
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles a granted stage may hold the port before a fault.
REQ-003 Parameter RO_MASK, default 8'b0101_0000, bit k=1 marks stage k read-only (stages 4 and 6).
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 nrst  input  1  synchronous, active-low reset.
REQ-006 en  input  1  level request to run one round of all enabled stages.
REQ-007 abort  input  1  synchronous abort of the current round.
REQ-008 skip_mask  input  8  bit k=1 bypasses stage k this round.
REQ-009 stage_done  input  8  per-stage completion level from each stage.
REQ-010 stage_start  output  8  one-hot one-cycle start pulse to the selected stage.
REQ-011 addr_select  output  3  address/data-in mux select for the shared memory port.
REQ-012 wr_select  output  3  write-enable mux select.
REQ-013 wr_gate  output  1  1 = current stage permitted to write memory.
REQ-014 busy  output  1  1 while a round is in progress (any state except IDLE).
REQ-015 round_done  output  1  one-cycle pulse at successful round end.
REQ-016 timeout  output  1  sticky fault flag.
REQ-017 fault_stage  output  3  index of the stage that timed out.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, FINISH, FAULT.
REQ-019 IDLE: on en=1, latch skip_mask; if all stages 0..NUM_STAGES-1 are skipped go to FINISH, else set cur to the lowest non-skipped index and go to ISSUE.
REQ-020 ISSUE (exactly one cycle): stage_start[cur]=1, wait counter cleared, next state WAIT.
REQ-021 WAIT: counter increments each cycle; stage_done[cur] is sampled only in WAIT, never in ISSUE.
REQ-022 WAIT with stage_done[cur]=1: go to ISSUE with cur = next higher non-skipped index, or to FINISH if none remains.
REQ-023 WAIT with counter = TIMEOUT-1 and stage_done[cur]=0: go to FAULT, set timeout=1, fault_stage=cur.
REQ-024 If done and the timeout boundary coincide in the same cycle, done SHALL win.
REQ-025 stage_done bits other than cur SHALL be ignored in every state.
REQ-026 FINISH (one cycle): round_done=1, next state IDLE; a new round starts only from IDLE when en=1, so a held en yields back-to-back rounds with exactly one IDLE cycle between them.
REQ-027 FAULT: hold until en=0, then go to IDLE; timeout and fault_stage stay set until reset or the next ISSUE.
REQ-028 abort=1 in any state SHALL force IDLE next cycle with no stage_start and no round_done; abort has priority over all other transitions.
REQ-029 addr_select and wr_select SHALL equal cur in ISSUE and WAIT, and 0 otherwise.
REQ-030 wr_gate SHALL be 1 only in WAIT with RO_MASK[cur]=0.
REQ-031 All outputs SHALL be registered; no combinational path from input to output.
REQ-032 The wait counter SHALL be $clog2(TIMEOUT)+1 bits wide and SHALL saturate, never wrap.

Reset
REQ-033 nrst=0 SHALL force IDLE; stage_start=0, addr_select=0, wr_select=0, wr_gate=0, busy=0, round_done=0, timeout=0, fault_stage=0, counter=0, cur=0.
REQ-034 Reset mid-round SHALL abandon the round with no pulse emitted on any output.

Structure
REQ-035 The state encoding, stage index constants (LEARN_COSTS=0 ... SELECT_ACTION=7) and default RO_MASK SHALL live in a shared package/include.
REQ-036 One sub-module, stage_timeout_counter (clear, enable, saturating, expired flag), SHALL implement the watchdog.

Verification
REQ-037 The bench SHALL cover: en=1, skip_mask=0, each stage_done raised 3 cycles after its start -> stage_start pulses 0..7 in order, wr_gate=0 during stages 4 and 6, one round_done pulse.
REQ-038 The bench SHALL cover: skip_mask=8'b0000_0110 -> stages 1 and 2 never started, stage 3 start occurs 1 cycle after the stage-0 done is sampled.
REQ-039 The bench SHALL cover: skip_mask=8'hFF -> round_done pulses 2 cycles after en, no stage_start.
REQ-040 The bench SHALL cover: TIMEOUT=16, stage 5 never done -> timeout=1 and fault_stage=5 after 16 WAIT cycles, recovery to IDLE after en drops.
REQ-041 The bench SHALL cover: abort asserted in WAIT of stage 3 -> IDLE next cycle, busy=0, no round_done.
REQ-042 The bench SHALL cover: a stale stage_done[cur]=1 held during ISSUE -> sampled only in WAIT; nrst pulled low mid-WAIT -> all outputs 0 next cycle.
